// File: rtl/tree_result_accumulator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tree_result_accumulator
// Sums cfg_len adder-tree partials, rescales and saturates each sum, and queues
// the results in an output FIFO.
// Revision: 1.0
// ============================================================================
module tree_result_accumulator #(
  parameter int IN_W       = 8,
  parameter int OUT_W      = 8,
  parameter int ACC_W      = 20,
  parameter int COUNT_W    = 8,
  parameter int SHIFT_W    = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [IN_W-1:0]    in_data_i,
  input  logic [COUNT_W-1:0] cfg_len_i,
  input  logic [SHIFT_W-1:0] cfg_shift_i,
  input  logic               clear_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [OUT_W-1:0]   out_data_o,
  output logic               busy_o,
  output logic               sat_flag_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic [COUNT_W-1:0] len_q, len_d;
  logic [SHIFT_W-1:0] shift_q, shift_d;
  logic               sat_q, sat_d;

  logic [OUT_W-1:0]   mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]     occ_q;

  logic               full_w, empty_w, accept_w, push_w, pop_w;
  logic               last_term_w, overflow_w;
  logic [COUNT_W-1:0] eff_len_w;
  logic [SHIFT_W-1:0] eff_shift_w;
  logic [ACC_W-1:0]   sum_w, shifted_w;
  logic [OUT_W-1:0]   push_data_w;

  assign full_w     = (occ_q == (PTR_W+1)'(FIFO_DEPTH));
  assign empty_w    = (occ_q == '0);
  assign in_ready_o = rst_n & ~full_w;
  assign accept_w   = in_valid_i & in_ready_o;

  // In IDLE the live config applies to the term being accepted; afterwards
  // the latched copy governs the rest of the element.
  assign eff_len_w   = (state_q == IDLE) ? ((cfg_len_i == '0) ? COUNT_W'(1) : cfg_len_i)
                                         : len_q;
  assign eff_shift_w = (state_q == IDLE) ? cfg_shift_i : shift_q;
  assign last_term_w = (({1'b0, count_q} + (COUNT_W+1)'(1)) == {1'b0, eff_len_w});

  assign sum_w       = acc_q + ACC_W'(in_data_i);
  assign shifted_w   = sum_w >> eff_shift_w;
  assign overflow_w  = |shifted_w[ACC_W-1:OUT_W];
  assign push_data_w = overflow_w ? {OUT_W{1'b1}} : shifted_w[OUT_W-1:0];

  assign push_w = accept_w & last_term_w & ~clear_i;
  assign pop_w  = ~empty_w & out_ready_i;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    len_d   = len_q;
    shift_d = shift_q;
    sat_d   = sat_q | (push_w & overflow_w);
    if (clear_i) begin
      state_d = IDLE;
      acc_d   = '0;
      count_d = '0;
    end else if (accept_w) begin
      if (last_term_w) begin
        state_d = IDLE;
        acc_d   = '0;
        count_d = '0;
      end else begin
        state_d = ACCUM;
        acc_d   = sum_w;
        count_d = count_q + COUNT_W'(1);
        if (state_q == IDLE) begin
          len_d   = eff_len_w;
          shift_d = eff_shift_w;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      count_q <= '0;
      len_q   <= COUNT_W'(1);
      shift_q <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      len_q   <= len_d;
      shift_q <= shift_d;
      sat_q   <= sat_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (push_w) begin
        mem_q[wr_ptr_q] <= push_data_w;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_w) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push_w, pop_w})
        2'b10:   occ_q <= occ_q + (PTR_W+1)'(1);
        2'b01:   occ_q <= occ_q - (PTR_W+1)'(1);
        default: occ_q <= occ_q;
      endcase
    end
  end

  assign out_valid_o = ~empty_w;
  assign out_data_o  = empty_w ? '0 : mem_q[rd_ptr_q];
  assign busy_o      = (count_q != '0) | ~empty_w;
  assign sat_flag_o  = sat_q;

endmodule
`default_nettype wire

// File: tb/tb_tree_result_accumulator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_tree_result_accumulator
// Directed stimulus with a queue scoreboard drained by a concurrent monitor.
// Revision: 1.0
// ============================================================================
module tb_tree_result_accumulator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid_i;
  logic       in_ready_o;
  logic [7:0] in_data_i;
  logic [7:0] cfg_len_i;
  logic [3:0] cfg_shift_i;
  logic       clear_i;
  logic       out_valid_o;
  logic       out_ready_i;
  logic [7:0] out_data_o;
  logic       busy_o;
  logic       sat_flag_o;

  int checks = 0;
  int errors = 0;
  int popped = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  tree_result_accumulator dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_data_i   (in_data_i),
    .cfg_len_i   (cfg_len_i),
    .cfg_shift_i (cfg_shift_i),
    .clear_i     (clear_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .busy_o      (busy_o),
    .sat_flag_o  (sat_flag_o)
  );

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Pops the scoreboard at every handshake, sampled mid-cycle.
  task automatic monitor();
    forever begin
      @(negedge clk);
      if (rst_n && out_valid_o && out_ready_i) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", int'(out_data_o), -1);
        end else begin
          chk("out_data", int'(out_data_o), exp_q.pop_front());
        end
        popped++;
      end
    end
  endtask

  // Leaves in_valid high so callers can stream back-to-back terms.
  task automatic send(input int term, input bit expect_out, input int expv);
    bit got;
    got = 1'b0;
    in_data_i  = term[7:0];
    in_valid_i = 1'b1;
    for (int k = 0; k < 30 && !got; k++) begin
      @(negedge clk);
      got = in_ready_o;
      @(posedge clk);
      #1;
    end
    if (!got) chk("accept_timeout", 0, 1);
    else if (expect_out) exp_q.push_back(expv);
  endtask

  initial begin
    rst_n       = 1'b0;
    in_valid_i  = 1'b0;
    in_data_i   = '0;
    cfg_len_i   = '0;
    cfg_shift_i = '0;
    clear_i     = 1'b0;
    out_ready_i = 1'b1;
    fork
      monitor();
    join_none

    #12;
    chk("rst_out_valid", int'(out_valid_o), 0);
    chk("rst_out_data",  int'(out_data_o),  0);
    chk("rst_in_ready",  int'(in_ready_o),  0);
    chk("rst_busy",      int'(busy_o),      0);
    chk("rst_sat",       int'(sat_flag_o),  0);
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("in_ready_after_rst", int'(in_ready_o), 1);

    // Basic group of four terms
    cfg_len_i = 8'd4; cfg_shift_i = 4'd0;
    send(10, 0, 0); send(20, 0, 0); send(30, 0, 0);
    chk("t1_no_early_valid", int'(out_valid_o), 0);
    chk("t1_busy_mid", int'(busy_o), 1);
    send(40, 1, 100);
    in_valid_i = 1'b0;
    chk("t1_latency_valid", int'(out_valid_o), 1);
    chk("t1_head", int'(out_data_o), 100);
    @(posedge clk); #1;
    chk("t1_drained_valid", int'(out_valid_o), 0);
    chk("t1_busy_idle", int'(busy_o), 0);

    // Shift and saturation
    cfg_len_i = 8'd3; cfg_shift_i = 4'd2;
    send(255, 0, 0); send(255, 0, 0); send(255, 1, 191);
    in_valid_i = 1'b0;
    chk("t2_sat_clear", int'(sat_flag_o), 0);
    cfg_shift_i = 4'd1;
    send(255, 0, 0); send(255, 0, 0); send(255, 1, 255);
    in_valid_i = 1'b0;
    chk("t2_sat_set", int'(sat_flag_o), 1);
    cfg_len_i = 8'd1; cfg_shift_i = 4'd0;
    send(3, 1, 3);
    in_valid_i = 1'b0;
    @(posedge clk); #1;
    chk("t2_sat_sticky", int'(sat_flag_o), 1);

    // Backpressure with a full FIFO
    repeat (3) @(posedge clk);
    #1 out_ready_i = 1'b0;
    send(1, 1, 1); send(2, 1, 2); send(3, 1, 3); send(4, 1, 4);
    chk("t3_full_ready", int'(in_ready_o), 0);
    in_data_i = 8'd5;
    repeat (3) begin
      @(posedge clk); #1;
      chk("t3_stall_ready", int'(in_ready_o), 0);
    end
    out_ready_i = 1'b1;
    send(5, 1, 5);
    chk("t3_pushpop_ready", int'(in_ready_o), 1);
    chk("t3_pushpop_valid", int'(out_valid_o), 1);
    send(6, 1, 6);
    in_valid_i = 1'b0;
    chk("t3_pushpop_ready2", int'(in_ready_o), 1);
    repeat (6) @(posedge clk);
    #1 chk("t3_drained", int'(out_valid_o), 0);

    // cfg_len of zero behaves as one
    cfg_len_i = 8'd0;
    send(7, 1, 7);
    chk("t4_valid_7", int'(out_valid_o), 1);
    chk("t4_head_7", int'(out_data_o), 7);
    send(9, 1, 9);
    in_valid_i = 1'b0;
    chk("t4_valid_9", int'(out_valid_o), 1);
    chk("t4_head_9", int'(out_data_o), 9);
    @(posedge clk); #1;

    // Clear discards the partial element and the coincident term
    cfg_len_i = 8'd4;
    send(5, 0, 0); send(5, 0, 0);
    clear_i = 1'b1;
    send(5, 0, 0);
    clear_i = 1'b0;
    in_valid_i = 1'b0;
    chk("t5_cleared_busy", int'(busy_o), 0);
    send(1, 0, 0); send(2, 0, 0); send(3, 0, 0); send(4, 1, 10);
    in_valid_i = 1'b0;
    repeat (10) @(posedge clk);

    // Asynchronous reset between edges
    #1 out_ready_i = 1'b0;
    cfg_len_i = 8'd1;
    send(1, 0, 0); send(2, 0, 0);
    cfg_len_i = 8'd4;
    send(3, 0, 0); send(3, 0, 0);
    in_valid_i = 1'b0;
    chk("t6_busy_pre", int'(busy_o), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_valid_rst", int'(out_valid_o), 0);
    chk("t6_ready_rst", int'(in_ready_o), 0);
    chk("t6_busy_rst",  int'(busy_o),     0);
    chk("t6_sat_rst",   int'(sat_flag_o), 0);
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready_i = 1'b1;
    cfg_len_i = 8'd2;
    send(3, 0, 0);
    chk("t6_no_early_valid", int'(out_valid_o), 0);
    send(4, 1, 7);
    in_valid_i = 1'b0;
    chk("t6_valid", int'(out_valid_o), 1);
    repeat (5) @(posedge clk);
    #1;
    chk("scoreboard_empty", exp_q.size(), 0);
    chk("total_outputs", popped, 14);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tree_result_accumulator.md
Name: tree_result_accumulator

Overview:
- Sits directly downstream of the adder-tree stage.
- Consumes the tree's 8-bit per-cycle partial result and accumulates cfg_len consecutive partial sums into one output element.
- Rescales the accumulated element by a right shift, saturates it to 8 bits, and queues it in a small output FIFO.
- The FIFO is drained through a valid/ready handshake toward the writeback/next-layer buffer.

Parameters:
IN_W, 8, width of the adder-tree result (unsigned)
OUT_W, 8, width of the saturated output element
ACC_W, 20, accumulator width; must satisfy ACC_W >= IN_W + COUNT_W
COUNT_W, 8, width of the terms-per-element counter and cfg_len
SHIFT_W, 4, width of cfg_shift
FIFO_DEPTH, 4, output FIFO entries (power of two, >= 2)

Ports:
clk  input  1  single clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
in_valid  input  1  adder-tree result valid this cycle
in_ready  output  1  block can accept a term this cycle
in_data  input  IN_W  adder-tree result, unsigned
cfg_len  input  COUNT_W  terms per output element; value 0 is treated as 1
cfg_shift  input  SHIFT_W  right-shift applied to the completed sum
clear  input  1  synchronous abort of the in-progress element
out_valid  output  1  FIFO head valid
out_ready  input  1  consumer accepts FIFO head
out_data  output  OUT_W  FIFO head element
busy  output  1  element in progress (term count != 0) or FIFO non-empty
sat_flag  output  1  sticky: an element saturated since the last reset

Behaviour:
- Reset (reset=0, asynchronous):
  - acc=0, term count=0.
  - FIFO empty: out_valid=0, out_data=0.
  - in_ready=0 while reset is asserted; busy=0; sat_flag=0.
- Accept rule: a term is accepted on a rising edge when in_valid && in_ready.
  - in_ready = reset deasserted && FIFO not full. It is independent of in_valid.
- FSM, two states:
  - IDLE: count==0.
  - ACCUM: count>0.
- Transitions:
  - IDLE, accept: latch len_q = max(cfg_len,1) and shift_q = cfg_shift.
    - If len_q==1, the element completes immediately and the state stays IDLE.
    - Otherwise acc=in_data, count=1, go to ACCUM.
  - ACCUM, accept, count+1 < len_q: acc += in_data, count++.
  - ACCUM, accept, count+1 == len_q: the element completes and the state returns to IDLE (acc=0, count=0).
  - cfg_len and cfg_shift changes during ACCUM are ignored until the next IDLE accept.
- Completion (same edge as the final accept):
  - sum = acc + in_data, zero-extended to ACC_W.
  - r = sum >> shift_q (logical shift).
  - If r > 2^OUT_W-1: push 2^OUT_W-1 and set sat_flag. Otherwise push r[OUT_W-1:0].
- Latency: out_valid rises the cycle after the final term's accept edge (1 cycle) when the FIFO was empty.
- FIFO behaviour:
  - Registered, first-word fall-through: out_data = head entry whenever out_valid=1.
  - Pop on out_valid && out_ready.
  - Push and pop on the same edge: occupancy unchanged, order preserved.
  - Full: in_ready=0, so no term is accepted and no push is lost. A pop while full reasserts in_ready on the next cycle.
  - Empty: out_valid=0; out_ready is ignored.
  - Pointers wrap modulo FIFO_DEPTH.
- clear=1 at an edge:
  - acc=0, count=0, state IDLE.
  - Any term accepted on that same edge is discarded.
  - FIFO contents and sat_flag are unaffected.
- Reset mid-element or with the FIFO non-empty discards everything. No output is produced for the partial element.
- No arithmetic overflow is possible in acc, given the ACC_W constraint.
- sat_flag clears only on reset.

Test Plan:
1. Basic group: cfg_len=4, cfg_shift=0, terms 10,20,30,40 on consecutive cycles, out_ready=1 -> one output of 100; out_valid high exactly 1 cycle after the 4th accept; busy returns to 0 afterwards.
2. Shift and saturate: cfg_len=3, terms 255,255,255 (sum 765).
   - cfg_shift=2 -> out_data=191, sat_flag=0.
   - Repeat with cfg_shift=1 -> out_data=255 (382 clipped) and sat_flag=1, which stays 1 through later non-saturating elements.
3. Backpressure: cfg_len=1, out_ready=0, in_valid held high with terms 1..6.
   - Expected: exactly 4 accepts, then in_ready=0.
   - Raise out_ready: outputs appear in order 1,2,3,4,5,6, with no loss or duplication.
   - A simultaneous push/pop cycle keeps occupancy constant.
4. cfg_len=0 is treated as 1: terms 7,9 -> outputs 7 and 9, each 1 cycle after its accept.
5. Clear mid-element: cfg_len=4, terms 5,5, then clear=1 coinciding with in_valid (term 5 discarded), then 1,2,3,4 -> single output of 10.
6. Async reset mid-operation: reset=0 asserted between clock edges with 2 FIFO entries and count=2.
   - Immediately: out_valid=0, in_ready=0, busy=0.
   - After release, a fresh group cfg_len=2 with terms 3,4 -> output 7 only.
